// File: rtl/lm32_tlb_nway_pkg.sv
// Shared TLB constants: CSR indices, maintenance command codes, FSM states.
package lm32_tlb_nway_pkg;

    localparam logic [4:0] CSR_TLB_PADDRESS = 5'h11;
    localparam logic [4:0] CSR_TLB_VADDRESS = 5'h12;

    localparam logic [4:0] TLB_CTRL_FLUSH          = 5'h01;
    localparam logic [4:0] TLB_CTRL_INVALIDATE_SET = 5'h10;

    localparam int TLB_PADDR_WRITABLE_BIT = 1;

    typedef enum logic {
        TLB_STATE_CHECK = 1'b0,
        TLB_STATE_FLUSH = 1'b1
    } tlb_state_t;

    // Command field of a TLB_VADDRESS write; bit 0 is the command strobe.
    function automatic logic [4:0] tlb_cmd(input logic [31:0] data);
        return data[5:1];
    endfunction

endpackage

// File: rtl/lm32_ram.sv
// Simple dual-port RAM with registered, enabled read; 1-cycle read latency.
// A read colliding with a write to the same address returns the old data.
module lm32_ram #(
    parameter int data_width    = 32,
    parameter int address_width = 8
) (
    input  logic                     clk_i,
    input  logic                     enable_read,
    input  logic [address_width-1:0] read_address,
    output logic [data_width-1:0]    read_data,
    input  logic                     write_enable,
    input  logic [address_width-1:0] write_address,
    input  logic [data_width-1:0]    write_data
);

    logic [data_width-1:0] mem [2**address_width];

    always_ff @(posedge clk_i) begin
        if (write_enable)
            mem[write_address] <= write_data;
        if (enable_read)
            read_data <= mem[read_address];
    end

endmodule

// File: rtl/lm32_tlb_way.sv
// One TLB way: entry RAM indexed in X, tag/ASID compare on the registered entry in M.
module lm32_tlb_way #(
    parameter int index_width = 8,
    parameter int tag_width   = 12,
    parameter int pfn_width   = 20,
    parameter int asid_width  = 8
) (
    input  logic                   clk_i,
    input  logic                   enable_read,
    input  logic [index_width-1:0] read_index,
    input  logic [tag_width-1:0]   tag_m,
    input  logic [asid_width-1:0]  asid,
    input  logic                   write_enable,
    input  logic [index_width-1:0] write_index,
    input  logic                   write_valid,
    input  logic                   write_writable,
    input  logic [asid_width-1:0]  write_asid,
    input  logic [tag_width-1:0]   write_tag,
    input  logic [pfn_width-1:0]   write_pfn,
    output logic                   hit,
    output logic                   writable,
    output logic [pfn_width-1:0]   pfn
);

    localparam int ENTRY_W = 2 + asid_width + tag_width + pfn_width;

    logic [ENTRY_W-1:0]    rd_entry;
    logic [ENTRY_W-1:0]    wr_entry;
    logic                  e_valid;
    logic [asid_width-1:0] e_asid;
    logic [tag_width-1:0]  e_tag;

    assign wr_entry = {write_valid, write_writable, write_asid, write_tag, write_pfn};

    lm32_ram #(
        .data_width    (ENTRY_W),
        .address_width (index_width)
    ) u_ram (
        .clk_i         (clk_i),
        .enable_read   (enable_read),
        .read_address  (read_index),
        .read_data     (rd_entry),
        .write_enable  (write_enable),
        .write_address (write_index),
        .write_data    (wr_entry)
    );

    assign {e_valid, writable, e_asid, e_tag, pfn} = rd_entry;
    assign hit = e_valid && (e_tag == tag_m) && (e_asid == asid);

endmodule

// File: rtl/lm32_tlb_nway.sv
// N-way set-associative TLB: X-stage indexed lookup, M-stage hit/translate/permission check.
// Round-robin victim per update; a flush sweep (also run out of reset) stalls the pipeline.
module lm32_tlb_nway
    import lm32_tlb_nway_pkg::*;
#(
    parameter int tlb_sets   = 256,
    parameter int tlb_ways   = 2,
    parameter int page_size  = 4096,
    parameter int asid_width = 8,
    parameter int fetch_mode = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_x,
    input  logic                  stall_m,
    input  logic [31:0]           address_x,
    input  logic [31:0]           address_m,
    input  logic                  access_m,
    input  logic                  write_m,
    input  logic                  tlb_enable,
    input  logic [asid_width-1:0] asid,
    input  logic [4:0]            csr,
    input  logic [31:0]           csr_write_data,
    input  logic                  csr_write_enable,
    input  logic                  exception_m,
    output logic [31:0]           physical_address_m,
    output logic                  miss,
    output logic                  fault,
    output logic                  stall_request,
    output logic [31:0]           csr_read_data
);

    localparam int OFFSET_W = $clog2(page_size);
    localparam int INDEX_W  = $clog2(tlb_sets);
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;
    localparam int PFN_W    = 32 - OFFSET_W;
    localparam int RR_W     = (tlb_ways > 1) ? $clog2(tlb_ways) : 1;

    tlb_state_t            state;
    logic [INDEX_W-1:0]    flush_set;
    logic [INDEX_W-1:0]    vaddr_index;
    logic [TAG_W-1:0]      vaddr_tag;
    logic                  updating;
    logic                  invalidating;
    logic                  update_writable;
    logic [asid_width-1:0] update_asid;
    logic [PFN_W-1:0]      update_pfn;
    logic [RR_W-1:0]       victim;
    logic                  miss_q;
    logic [31:0]           miss_addr;

    logic                  cmd_write;
    logic                  vaddr_cmd;
    logic                  paddr_cmd;
    logic                  flushing;
    logic                  do_clear;
    logic                  do_update;
    logic [INDEX_W-1:0]    wr_index;
    logic                  read_enable;
    logic [tlb_ways-1:0]   way_hit;
    logic [tlb_ways-1:0]   way_writable;
    logic [PFN_W-1:0]      way_pfn [tlb_ways];
    logic                  any_hit;
    logic                  hit_writable;
    logic [PFN_W-1:0]      hit_pfn;
    logic                  miss_c;
    logic                  fault_c;
    logic                  unused_bits;

    assign unused_bits = ^{address_x, address_m, csr_write_data};

    // Maintenance commands are only honoured while not sweeping.
    assign cmd_write = csr_write_enable && csr_write_data[0] && (state == TLB_STATE_CHECK);
    assign vaddr_cmd = cmd_write && (csr == CSR_TLB_VADDRESS);
    assign paddr_cmd = cmd_write && (csr == CSR_TLB_PADDRESS);

    // Single write port per way: sweep/invalidate take priority over an update.
    assign flushing  = (state == TLB_STATE_FLUSH);
    assign do_clear  = flushing || invalidating;
    assign do_update = updating && !do_clear;
    assign wr_index  = flushing ? flush_set : vaddr_index;

    assign read_enable = !stall_x || !stall_m;

    for (genvar g = 0; g < tlb_ways; g++) begin : g_way
        lm32_tlb_way #(
            .index_width (INDEX_W),
            .tag_width   (TAG_W),
            .pfn_width   (PFN_W),
            .asid_width  (asid_width)
        ) u_way (
            .clk_i          (clk_i),
            .enable_read    (read_enable),
            .read_index     (address_x[OFFSET_W +: INDEX_W]),
            .tag_m          (address_m[OFFSET_W + INDEX_W +: TAG_W]),
            .asid           (asid),
            .write_enable   (do_clear || (do_update && (victim == RR_W'(g)))),
            .write_index    (wr_index),
            .write_valid    (do_update),
            .write_writable (update_writable),
            .write_asid     (update_asid),
            .write_tag      (vaddr_tag),
            .write_pfn      (update_pfn),
            .hit            (way_hit[g]),
            .writable       (way_writable[g]),
            .pfn            (way_pfn[g])
        );
    end

    // Lowest-numbered hitting way wins.
    always_comb begin
        hit_writable = 1'b0;
        hit_pfn      = '0;
        for (int i = tlb_ways - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_writable = way_writable[i];
                hit_pfn      = way_pfn[i];
            end
        end
    end

    assign any_hit = |way_hit;
    assign miss_c  = tlb_enable && access_m && !any_hit;
    assign fault_c = (fetch_mode == 0) && tlb_enable && access_m && write_m && any_hit && !hit_writable;

    assign physical_address_m = tlb_enable ? {hit_pfn, address_m[OFFSET_W-1:0]} : address_m;
    assign miss               = tlb_enable && (miss_c || miss_q);
    assign fault              = fault_c;
    assign stall_request      = tlb_enable && flushing;
    assign csr_read_data      = miss_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= TLB_STATE_FLUSH;
            flush_set       <= '1;
            vaddr_index     <= '0;
            vaddr_tag       <= '0;
            updating        <= 1'b0;
            invalidating    <= 1'b0;
            update_writable <= 1'b0;
            update_asid     <= '0;
            update_pfn      <= '0;
            victim          <= '0;
        end else begin
            updating     <= paddr_cmd;
            invalidating <= vaddr_cmd && (tlb_cmd(csr_write_data) == TLB_CTRL_INVALIDATE_SET);
            if (vaddr_cmd) begin
                vaddr_index <= csr_write_data[OFFSET_W +: INDEX_W];
                vaddr_tag   <= csr_write_data[OFFSET_W + INDEX_W +: TAG_W];
            end
            if (paddr_cmd) begin
                update_writable <= csr_write_data[TLB_PADDR_WRITABLE_BIT];
                update_asid     <= asid;
                update_pfn      <= csr_write_data[OFFSET_W +: PFN_W];
            end
            if (do_update)
                victim <= (victim == RR_W'(tlb_ways - 1)) ? '0 : victim + 1'b1;
            if (flushing) begin
                flush_set <= flush_set - 1'b1;
                if (flush_set == '0)
                    state <= TLB_STATE_CHECK;
            end else if (vaddr_cmd && (tlb_cmd(csr_write_data) == TLB_CTRL_FLUSH)) begin
                state     <= TLB_STATE_FLUSH;
                flush_set <= '1;
            end
        end
    end

    // Sticky miss/fault: exception clears, and wins over a simultaneous new miss.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_q    <= 1'b0;
            miss_addr <= '0;
        end else begin
            if ((miss_c || fault_c) && !miss_q)
                miss_addr <= address_m;
            if (exception_m)
                miss_q <= 1'b0;
            else if (miss_c || fault_c)
                miss_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lm32_tlb_nway.sv
// Directed bench for lm32_tlb_nway: table of lookups plus hand sequences for flush, eviction, fault, invalidate.
module tb_lm32_tlb_nway;
    import lm32_tlb_nway_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_x = 1'b0;
    logic        stall_m = 1'b0;
    logic [31:0] address_x = '0;
    logic [31:0] address_m = '0;
    logic        access_m = 1'b0;
    logic        write_m = 1'b0;
    logic        tlb_enable = 1'b1;
    logic [7:0]  asid = 8'd5;
    logic [4:0]  csr = '0;
    logic [31:0] csr_write_data = '0;
    logic        csr_write_enable = 1'b0;
    logic        exception_m = 1'b0;
    logic [31:0] physical_address_m;
    logic        miss;
    logic        fault;
    logic        stall_request;
    logic [31:0] csr_read_data;

    lm32_tlb_nway dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .stall_x            (stall_x),
        .stall_m            (stall_m),
        .address_x          (address_x),
        .address_m          (address_m),
        .access_m           (access_m),
        .write_m            (write_m),
        .tlb_enable         (tlb_enable),
        .asid               (asid),
        .csr                (csr),
        .csr_write_data     (csr_write_data),
        .csr_write_enable   (csr_write_enable),
        .exception_m        (exception_m),
        .physical_address_m (physical_address_m),
        .miss               (miss),
        .fault              (fault),
        .stall_request      (stall_request),
        .csr_read_data      (csr_read_data)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  asid;
        logic        en;
        logic        exp_miss;
        logic        exp_fault;
        logic        chk_pa;
        logic [31:0] exp_pa;
    } vec_t;

    vec_t vecs [8];

    int tests  = 0;
    int failed = 0;

    logic        s_miss;
    logic        s_fault;
    logic [31:0] s_pa;
    logic        s_sticky;
    logic [31:0] s_csr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk_i);
        csr              = idx;
        csr_write_data   = data;
        csr_write_enable = 1'b1;
        @(negedge clk_i);
        csr_write_enable = 1'b0;
    endtask

    task automatic tlb_update(input logic [31:0] vaddr, input logic [31:0] paddr);
        csr_write(CSR_TLB_VADDRESS, vaddr);
        csr_write(CSR_TLB_PADDRESS, paddr);
        @(negedge clk_i);
    endtask

    // X-stage read, M-stage sample, then a sticky-state sample and an exception to clear it.
    task automatic lookup(input logic [31:0] a, input logic wr, input logic [7:0] s, input logic en);
        @(negedge clk_i);
        address_x   = a;
        access_m    = 1'b0;
        exception_m = 1'b0;
        @(negedge clk_i);
        address_m  = a;
        access_m   = 1'b1;
        write_m    = wr;
        asid       = s;
        tlb_enable = en;
        #1;
        s_miss  = miss;
        s_fault = fault;
        s_pa    = physical_address_m;
        @(negedge clk_i);
        access_m = 1'b0;
        write_m  = 1'b0;
        #1;
        s_sticky    = miss;
        s_csr       = csr_read_data;
        exception_m = 1'b1;
        @(negedge clk_i);
        exception_m = 1'b0;
        asid        = 8'd5;
        tlb_enable  = 1'b1;
    endtask

    task automatic count_stall(input string name);
        int cnt;
        cnt = 0;
        #1;
        while (stall_request && cnt < 1000) begin
            cnt++;
            @(negedge clk_i);
            #1;
        end
        check(name, cnt, 256);
    endtask

    initial begin
        vecs[0] = '{32'h00403ABC, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h12345ABC};
        vecs[1] = '{32'h00403ABC, 1'b0, 8'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{32'h00503010, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22222010};
        vecs[3] = '{32'h00503010, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22222010};
        vecs[4] = '{32'h00413ABC, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{32'h00404ABC, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{32'hDEADBEE0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEE0};
        vecs[7] = '{32'h00403ABC, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00403ABC};

        // Reset state and the power-on flush sweep.
        repeat (3) @(negedge clk_i);
        #1;
        check("reset_stall_request", stall_request, 1);
        check("reset_miss", miss, 0);
        check("reset_csr_read_data", csr_read_data, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        count_stall("reset_flush_cycles");

        lookup(32'h00001234, 1'b0, 8'd5, 1'b1);
        check("empty_miss", s_miss, 1);
        check("empty_miss_addr", s_csr, 32'h00001234);

        tlb_update(32'h00403001, 32'h12345003);
        tlb_update(32'h00503001, 32'h22222003);

        for (int i = 0; i < 8; i++) begin
            lookup(vecs[i].addr, vecs[i].wr, vecs[i].asid, vecs[i].en);
            check($sformatf("vec%0d_miss", i), s_miss, vecs[i].exp_miss);
            check($sformatf("vec%0d_fault", i), s_fault, vecs[i].exp_fault);
            if (vecs[i].chk_pa)
                check($sformatf("vec%0d_pa", i), s_pa, vecs[i].exp_pa);
        end

        // Third entry in set 3 wraps the round-robin and evicts the first.
        tlb_update(32'h00603001, 32'h44444003);
        lookup(32'h00403ABC, 1'b0, 8'd5, 1'b1);
        check("evicted_a_miss", s_miss, 1);
        lookup(32'h00503010, 1'b0, 8'd5, 1'b1);
        check("kept_b_miss", s_miss, 0);
        check("kept_b_pa", s_pa, 32'h22222010);
        lookup(32'h00603FFF, 1'b0, 8'd5, 1'b1);
        check("new_c_miss", s_miss, 0);
        check("new_c_pa", s_pa, 32'h44444FFF);

        // Read-only entry: loads pass, stores fault and set the sticky flag.
        tlb_update(32'h00704001, 32'h33333001);
        lookup(32'h00704123, 1'b0, 8'd5, 1'b1);
        check("ro_load_miss", s_miss, 0);
        check("ro_load_fault", s_fault, 0);
        check("ro_load_pa", s_pa, 32'h33333123);
        lookup(32'h00704123, 1'b1, 8'd5, 1'b1);
        check("ro_store_fault", s_fault, 1);
        check("ro_store_miss", s_miss, 0);
        check("ro_store_sticky", s_sticky, 1);
        check("ro_store_addr", s_csr, 32'h00704123);
        #1;
        check("sticky_cleared", miss, 0);

        // Invalidate set 3 only.
        csr_write(CSR_TLB_VADDRESS, 32'h00003021);
        @(negedge clk_i);
        lookup(32'h00503010, 1'b0, 8'd5, 1'b1);
        check("inv_b_miss", s_miss, 1);
        lookup(32'h00603FFF, 1'b0, 8'd5, 1'b1);
        check("inv_c_miss", s_miss, 1);
        lookup(32'h00704123, 1'b0, 8'd5, 1'b1);
        check("inv_set4_miss", s_miss, 0);
        check("inv_set4_pa", s_pa, 32'h33333123);

        // Software flush.
        csr_write(CSR_TLB_VADDRESS, 32'h00000003);
        count_stall("cmd_flush_cycles");
        lookup(32'h00704123, 1'b0, 8'd5, 1'b1);
        check("flushed_miss", s_miss, 1);

        // Translation disabled on an empty TLB.
        lookup(32'hDEADBEE0, 1'b0, 8'd5, 1'b0);
        check("off_load_pa", s_pa, 32'hDEADBEE0);
        check("off_load_miss", s_miss, 0);
        lookup(32'hDEADBEE0, 1'b1, 8'd5, 1'b0);
        check("off_store_miss", s_miss, 0);
        check("off_store_fault", s_fault, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lm32_tlb_nway.md
Name: lm32_tlb_nway

Overview:
- Parametrised N-way set-associative TLB for the LM32 load/store path (instruction path via `fetch_mode`); next generation of the single-way data TLB.
- Lookup indexed from the X-stage address; hit, translation and permission check resolved in M.
- Adds per-entry ASID tag, per-entry writable bit and round-robin way replacement.
- Maintained through the TLB_VADDRESS / TLB_PADDRESS CSRs; a flush sweep FSM stalls the pipeline.

Parameters:
- tlb_sets, 256, sets per way (power of 2, >=2)
- tlb_ways, 2, associativity (1, 2 or 4)
- page_size, 4096, page size in bytes (power of 2, >=8)
- asid_width, 8, address-space identifier width
- fetch_mode, 0, 1 = instruction TLB: write permission ignored, `fault` forced low

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- stall_x  in  1  X stage stalled
- stall_m  in  1  M stage stalled
- address_x  in  32  X-stage virtual address
- address_m  in  32  M-stage virtual address
- access_m  in  1  valid load/store/fetch in M
- write_m  in  1  M access is a store
- tlb_enable  in  1  translation enable (PSW bit)
- asid  in  asid_width  current address-space id
- csr  in  5  CSR index
- csr_write_data  in  32  CSR write data
- csr_write_enable  in  1  CSR write strobe
- exception_m  in  1  exception taken in M
- physical_address_m  out  32  translated address (`address_m` when disabled)
- miss  out  1  M-stage miss, combinational, OR sticky miss_q
- fault  out  1  store hit on non-writable entry
- stall_request  out  1  flush sweep in progress while enabled
- csr_read_data  out  32  last miss/fault virtual address

Behaviour:
- Entry per way: {valid, writable, asid, vtag, pfn}. vtag = address bits above the index field. One lm32_ram per way. Read enable = !stall_x || !stall_m, giving 1-cycle read latency X->M.
- Hit, way i: valid & vtag == address_m tag & entry asid == `asid`. Lowest-numbered hitting way wins; multiple hits are legal but unspecified for software.
- physical_address_m = {pfn_hit, address_m page offset}. On miss the pfn is don't-care.
- miss = tlb_enable & access_m & !any_hit.
- fault = tlb_enable & access_m & write_m & hit & !writable.
- miss_q:
  - Sets on miss or fault.
  - Clears on exception_m. If exception_m and a new miss occur in the same cycle, clear wins.
  - Reset 0.
- miss_addr:
  - Captures address_m on the first cycle of miss/fault only, i.e. while miss_q = 0.
  - Reset 0. Drives csr_read_data.
- CSR side (commands take effect only when csr_write_data[0] = 1):
  - Write to TLB_VADDRESS with bit 0 set: latch bits 31:1 into vaddr_reg. Command field [5:1]:
    - 0x01 FLUSH: enter FLUSH state.
    - 0x10 INVALIDATE: one cycle later, clear the valid bit of all ways at the set given by csr_write_data's index field.
    - Any other value: latch only.
  - Write to TLB_PADDRESS with bit 0 set: next cycle writes {1, csr_write_data[1], asid, vaddr_reg tag, csr_write_data pfn} into the victim way at the vaddr_reg index. Bit 1 = writable.
- Victim selection: global round-robin counter, CLOG2(tlb_ways) bits, reset 0. Increments after each update and wraps from tlb_ways-1 to 0.
- FSM states:
  - CHECK: normal lookups; CSR commands accepted.
  - FLUSH: flush_set counts down from tlb_sets-1, writing valid = 0 to all ways each cycle. At flush_set = 0, return to CHECK (tlb_sets cycles total). Underflow of flush_set is harmless.
- CSR commands arriving in FLUSH are ignored, including updates. Software must not issue them.
- Reset mid-operation restarts a full flush: state FLUSH, flush_set = all ones, updating = 0. stall_request is high from reset release until the sweep ends, provided tlb_enable is high.
- If an update and an invalidate target the same cycle, invalidate wins. At most one RAM write occurs per cycle.
- tlb_enable = 0: pass-through; miss and fault held low. Maintenance commands still execute.

Decomposition:
- Shared include (lm32_include.v additions):
  - `LM32_TLB_CTRL_FLUSH` = 5'h01
  - `LM32_TLB_CTRL_INVALIDATE_SET` = 5'h10
  - state encodings `LM32_TLB_STATE_CHECK` / `LM32_TLB_STATE_FLUSH`
  - PADDRESS writable bit position
- Sub-module: lm32_tlb_way. Wraps one lm32_ram plus tag/ASID compare; outputs hit, writable, pfn. Instantiated tlb_ways times by generate.

Test Plan:
- Reset with tlb_enable = 1 -> stall_request high for exactly 256 cycles (default tlb_sets); an access_m afterwards gives miss = 1, csr_read_data = address_m.
- Update vaddr 0x00403001, paddr 0x12345003 (writable), asid 5; load 0x00403ABC -> physical 0x12345ABC, miss = 0. Same load with asid = 6 -> miss = 1.
- Two updates to index 3 with tags A then B, ways = 2 -> both hit. A third update with tag C evicts A (round-robin wrap) -> A misses, B and C hit.
- Entry with paddr bit 1 = 0: load hits with fault = 0; store gives fault = 1, miss_q set. exception_m clears miss_q the next cycle.
- INVALIDATE on set 3 -> all ways at set 3 miss; entries at set 4 still hit. FLUSH command -> stall for tlb_sets cycles, then all entries miss.
- tlb_enable = 0: physical_address_m == address_m for 0xDEADBEE0; miss and fault remain 0 with an empty TLB.
